// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of the DMEM SRAM.
// Validates size/range/alignment, issues one SRAM strobe, returns extended load data or an error code.
module dmem_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_4000,
    parameter int unsigned DMEM_BYTES = 49152,
    parameter int unsigned WADDR_W    = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               req_we,
    input  logic [1:0]         req_n_bytes,
    input  logic               req_unsigned,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam logic [31:0] DMEM_END = DMEM_BASE + DMEM_BYTES;

    localparam logic [1:0] NB_WORD = 2'b00;
    localparam logic [1:0] NB_BYTE = 2'b01;
    localparam logic [1:0] NB_HALF = 2'b10;
    localparam logic [1:0] NB_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RDW, S_RSP} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]         r_lane;
    logic               r_we;
    logic [1:0]         r_nbytes;
    logic               r_unsigned;

    logic               r_req_ready,   w_req_ready;
    logic               r_rsp_valid,   w_rsp_valid;
    logic [31:0]        r_rsp_rdata,   w_rsp_rdata;
    logic [1:0]         r_rsp_err,     w_rsp_err;
    logic               r_mem_en,      w_mem_en;
    logic               r_mem_we,      w_mem_we;
    logic [3:0]         r_mem_be,      w_mem_be;
    logic [WADDR_W-1:0] r_mem_addr,    w_mem_addr;
    logic [31:0]        r_mem_wdata,   w_mem_wdata;

    logic               w_accept;
    logic [1:0]         w_err;
    logic [WADDR_W-1:0] w_word_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load;

    assign w_accept   = req_valid && r_req_ready && (r_state == S_IDLE);
    assign w_word_idx = WADDR_W'((req_addr - DMEM_BASE) >> 2);

    always_comb begin
        w_err = ERR_OK;
        if (req_n_bytes == NB_ILL) begin
            w_err = ERR_SIZE;
        end else if ((req_addr < DMEM_BASE) || (req_addr >= DMEM_END)) begin
            w_err = ERR_RANGE;
        end else if (((req_n_bytes == NB_HALF) && req_addr[0]) ||
                     ((req_n_bytes == NB_WORD) && (req_addr[1:0] != 2'b00))) begin
            w_err = ERR_MISALIGN;
        end
    end

    // Store data is replicated across lanes; byte enables pick the live lane(s).
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_n_bytes)
            NB_BYTE: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            NB_HALF: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    assign w_shifted = mem_rdata >> {r_lane, 3'b000};

    always_comb begin
        case (r_nbytes)
            NB_BYTE: w_load = {{24{w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
            NB_HALF: w_load = {{16{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    w_req_ready = 1'b0;
                    if (w_err != ERR_OK) begin
                        w_state_nxt = S_RSP;
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = '0;
                        w_rsp_err   = w_err;
                    end else begin
                        w_state_nxt = S_ACC;
                        w_mem_en    = 1'b1;
                        w_mem_we    = req_we;
                        w_mem_be    = w_be;
                        w_mem_addr  = w_word_idx;
                        w_mem_wdata = w_wdata;
                    end
                end
            end
            S_ACC: begin
                if (r_we) begin
                    w_state_nxt = S_RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = '0;
                    w_rsp_err   = ERR_OK;
                end else begin
                    w_state_nxt = S_RDW;
                end
            end
            S_RDW: begin
                w_state_nxt = S_RSP;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = w_load;
                w_rsp_err   = ERR_OK;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_lane      <= '0;
            r_we        <= 1'b0;
            r_nbytes    <= '0;
            r_unsigned  <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_be    <= w_mem_be;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            if (w_accept) begin
                r_lane     <= req_addr[1:0];
                r_we       <= req_we;
                r_nbytes   <= req_n_bytes;
                r_unsigned <= req_unsigned;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
